// File: rtl/iir_pkg.sv
// Shared constants and state encodings for the IIR cascade controller.
package iir_pkg;
  localparam int SAMP_WH_D  = 4;
  localparam int SAMP_FR_D  = 23;
  localparam int COEFF_WH_D = 2;
  localparam int COEFF_FR_D = 14;

  localparam logic [1:0] C_A0 = 2'd0;
  localparam logic [1:0] C_A1 = 2'd1;
  localparam logic [1:0] C_B  = 2'd2;
  localparam logic [1:0] C_K  = 2'd3;

  typedef enum logic [2:0] {IDLE, F1, F2, F3, F4, CAP} frame_state_e;
  typedef enum logic [1:0] {LD_IDLE, LD_RUN, LD_LAST} load_state_e;
endpackage

// File: rtl/iir_coef_loader.sv
// Streams 4*N_SEC coefficients from a synchronous ROM into the sections.
module iir_coef_loader
  import iir_pkg::*;
#(
  parameter int N_SEC = 4,
  parameter int CW    = 16,
  localparam int AW   = $clog2(4 * N_SEC)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_i,
  input  logic [CW-1:0]     rom_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AW-1:0]     rom_addr_o,
  output logic [N_SEC-1:0]  c_we_o,
  output logic [1:0]        c_addr_o,
  output logic [CW-1:0]     c_in_o
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(4 * N_SEC - 1);

  load_state_e   st_q, st_d;
  logic [AW-1:0] addr_q, addr_d, wr_idx_q;
  logic          wr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q     <= LD_IDLE;
      addr_q   <= '0;
      wr_idx_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      // ROM answers one cycle late, so the write trails the address by one.
      wr_q     <= (st_q == LD_RUN);
      wr_idx_q <= addr_q;
    end
  end

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    case (st_q)
      LD_IDLE: if (start_i) st_d = LD_RUN;
      LD_RUN: begin
        if (addr_q == LAST_ADDR) begin
          st_d   = LD_LAST;
          addr_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      LD_LAST: st_d = LD_IDLE;
      default: st_d = LD_IDLE;
    endcase
  end

  assign busy_o     = (st_q != LD_IDLE);
  assign done_o     = (st_q == LD_LAST);
  assign rom_addr_o = addr_q;
  assign c_we_o     = wr_q ? (N_SEC'(1) << (wr_idx_q >> 2)) : '0;
  assign c_addr_o   = wr_idx_q[1:0];
  assign c_in_o     = wr_q ? rom_data_i : '0;
endmodule

// File: rtl/iir_cascade_ctrl.sv
// Frame sequencer for a lock-step cascade of biquad sections plus coefficient loader.
module iir_cascade_ctrl
  import iir_pkg::*;
#(
  parameter int N_SEC    = 4,
  parameter int SAMP_WH  = SAMP_WH_D,
  parameter int SAMP_FR  = SAMP_FR_D,
  parameter int COEFF_WH = COEFF_WH_D,
  parameter int COEFF_FR = COEFF_FR_D,
  localparam int SW      = SAMP_WH + SAMP_FR,
  localparam int CW      = COEFF_WH + COEFF_FR,
  localparam int AW      = $clog2(4 * N_SEC)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_start,
  output logic              load_busy,
  output logic [AW-1:0]     rom_addr,
  input  logic [CW-1:0]     rom_data,
  output logic [N_SEC-1:0]  c_we,
  output logic [1:0]        c_addr,
  output logic [CW-1:0]     c_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SW-1:0]     din,
  output logic [SW-1:0]     sec_din,
  output logic              ce,
  output logic              mult_sel,
  input  logic [SW-1:0]     last_dout,
  output logic [SW-1:0]     dout,
  output logic              out_valid
);
  localparam logic [3:0] WARM_MAX = 4'(N_SEC);
  localparam logic [3:0] WARM_MIN = 4'(N_SEC - 1);

  frame_state_e fs_q, fs_d;
  logic [SW-1:0] sec_din_q, dout_q;
  logic          out_valid_q, pend_q;
  logic [3:0]    warm_q;
  logic          f_idle, go, accept, ld_done;

  assign f_idle   = (fs_q == IDLE);
  // A pending or fresh load request takes the idle slot ahead of any sample.
  assign go       = f_idle && !load_busy && (load_start || pend_q);
  assign in_ready = nrst && f_idle && !load_busy && !go;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fs_d = fs_q;
    case (fs_q)
      IDLE:    if (accept) fs_d = F1;
      F1:      fs_d = F2;
      F2:      fs_d = F3;
      F3:      fs_d = F4;
      F4:      fs_d = CAP;
      CAP:     fs_d = IDLE;
      default: fs_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fs_q        <= IDLE;
      sec_din_q   <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      warm_q      <= '0;
    end else begin
      fs_q        <= fs_d;
      out_valid_q <= (fs_q == CAP) && (warm_q >= WARM_MIN);
      if (accept) sec_din_q <= din;
      if (fs_q == CAP) dout_q <= last_dout;
      if (go) pend_q <= 1'b0;
      else if (load_start && !f_idle) pend_q <= 1'b1;
      if (ld_done) warm_q <= '0;
      else if (fs_q == CAP && warm_q != WARM_MAX) warm_q <= warm_q + 1'b1;
    end
  end

  assign ce        = (fs_q == F2) || (fs_q == F3);
  assign mult_sel  = ce;
  assign sec_din   = sec_din_q;
  assign dout      = dout_q;
  assign out_valid = out_valid_q;

  iir_coef_loader #(
    .N_SEC (N_SEC),
    .CW    (CW)
  ) u_loader (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (go),
    .rom_data_i (rom_data),
    .busy_o     (load_busy),
    .done_o     (ld_done),
    .rom_addr_o (rom_addr),
    .c_we_o     (c_we),
    .c_addr_o   (c_addr),
    .c_in_o     (c_in)
  );
endmodule

// File: tb/tb_iir_cascade_ctrl.sv
// Directed bench for iir_cascade_ctrl with a ROM model and unity-passthrough sections.
module tb_iir_cascade_ctrl;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        load_start = 1'b0;
  logic        load_busy;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [3:0]  c_we;
  logic [1:0]  c_addr;
  logic [15:0] c_in;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] din = '0;
  logic [26:0] sec_din;
  logic        ce, mult_sel;
  logic [26:0] last_dout;
  logic [26:0] dout;
  logic        out_valid;

  int total = 0;
  int bad = 0;

  iir_cascade_ctrl #(
    .N_SEC    (4),
    .SAMP_WH  (4),
    .SAMP_FR  (23),
    .COEFF_WH (2),
    .COEFF_FR (14)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .load_start (load_start),
    .load_busy  (load_busy),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_in       (c_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .sec_din    (sec_din),
    .ce         (ce),
    .mult_sel   (mult_sel),
    .last_dout  (last_dout),
    .dout       (dout),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [3:0] a);
    return 16'hA000 ^ (16'(a) * 16'h0123);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Unity sections: update on ce falling edge, each stage passes its predecessor's output.
  logic [26:0] sec_out [4] = '{default: '0};
  logic        ce_d = 1'b0;
  always @(posedge clk) begin
    ce_d <= ce;
    if (ce_d && !ce) begin
      sec_out[0] <= sec_din;
      for (int k = 1; k < 4; k++) sec_out[k] <= sec_out[k-1];
    end
  end
  assign last_dout = sec_out[3];

  typedef struct {
    logic [3:0]  we;
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_vec_t;

  typedef struct {
    logic ready;
    logic ce;
    logic msel;
  } fr_vec_t;

  wr_vec_t     wtab [16];
  fr_vec_t     ftab [7];
  logic [26:0] hist [$];
  logic [26:0] ns = 27'h0100001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int i = 0;
    while (!in_ready && i < 20) begin
      tick();
      i++;
    end
    if (!in_ready) chk("wait_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Continuous in_valid; checks strobe cadence, warm-up suppression and dout latency.
  task automatic stream(input int nfr, input int warm0);
    int acc = 0, caps = 0, last_acc = 0, cyc = 0, n, w;
    in_valid = 1'b1;
    while (acc < nfr && cyc < nfr * 6 + 12) begin
      din = ns;
      #1;
      if (in_ready) begin
        if (acc > 0) begin
          n = hist.size() - 1;
          w = warm0 + caps;
          chk("stream_valid", 32'(out_valid), 32'(w >= 3));
          if (w >= 3) chk("stream_dout", 32'(dout), 32'(hist[n-3]));
          chk("stream_period", 32'(cyc - last_acc), 32'd6);
          caps++;
        end
        hist.push_back(din);
        ns = ns + 27'h0011111;
        acc++;
        last_acc = cyc;
      end else begin
        chk("stream_nostrobe", 32'(out_valid), 32'd0);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (acc < nfr) chk("stream_timeout", 32'(acc), 32'(nfr));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++)
      wtab[i] = '{we: 4'b0001 << (i / 4), addr: 2'(i % 4), data: rom_fn(4'(i))};
    ftab[0] = '{1'b1, 1'b0, 1'b0};
    ftab[1] = '{1'b0, 1'b0, 1'b0};
    ftab[2] = '{1'b0, 1'b1, 1'b1};
    ftab[3] = '{1'b0, 1'b1, 1'b1};
    ftab[4] = '{1'b0, 1'b0, 1'b0};
    ftab[5] = '{1'b0, 1'b0, 1'b0};
    ftab[6] = '{1'b1, 1'b0, 1'b0};

    // Reset values
    tick(); tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_we", 32'(c_we), 32'd0);
    chk("rst_c_in", 32'(c_in), 32'd0);
    chk("rst_c_addr", 32'(c_addr), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_msel", 32'(mult_sel), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sec_din", 32'(sec_din), 32'd0);
    nrst = 1'b1;
    #1;
    chk("first_ready", 32'(in_ready), 32'd1);

    // Coefficient load
    load_start = 1'b1;
    #1;
    chk("load_req_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 18; k++) begin
      tick();
      load_start = 1'b0;
      #1;
      chk("load_busy", 32'(load_busy), 32'(k <= 17));
      if (k <= 17) chk("load_ready", 32'(in_ready), 32'd0);
      if (k >= 1 && k <= 16) chk("load_rom_addr", 32'(rom_addr), 32'(k - 1));
      if (k >= 2 && k <= 17) begin
        chk("load_we", 32'(c_we), 32'(wtab[k-2].we));
        chk("load_addr", 32'(c_addr), 32'(wtab[k-2].addr));
        chk("load_data", 32'(c_in), 32'(wtab[k-2].data));
      end else begin
        chk("load_we_idle", 32'(c_we), 32'd0);
      end
    end

    // Single sample frame
    in_valid = 1'b1;
    din = 27'h0400000;
    #1;
    chk("frame0_ready", 32'(in_ready), 32'(ftab[0].ready));
    chk("frame0_ce", 32'(ce), 32'(ftab[0].ce));
    hist.push_back(din);
    for (int k = 1; k <= 6; k++) begin
      tick();
      in_valid = 1'b0;
      #1;
      chk("frame_ready", 32'(in_ready), 32'(ftab[k].ready));
      chk("frame_ce", 32'(ce), 32'(ftab[k].ce));
      chk("frame_msel", 32'(mult_sel), 32'(ftab[k].msel));
      chk("frame_valid", 32'(out_valid), 32'd0);
      chk("frame_sec_din", 32'(sec_din), 32'h0400000);
    end

    // Back-to-back samples; one capture already counted since the load
    stream(8, 1);

    // Load request during F2 is deferred to the next idle slot
    wait_ready();
    in_valid = 1'b1;
    din = ns;
    #1;
    hist.push_back(din);
    ns = ns + 27'h0011111;
    tick();
    in_valid = 1'b0;
    tick();
    chk("defer_f2_ce", 32'(ce), 32'd1);
    load_start = 1'b1;
    #1;
    chk("defer_req_busy", 32'(load_busy), 32'd0);
    tick();
    load_start = 1'b0;
    in_valid = 1'b1;
    din = 27'h7777777;
    tick();
    tick();
    chk("defer_cap_busy", 32'(load_busy), 32'd0);
    tick();
    chk("defer_idle_busy", 32'(load_busy), 32'd0);
    chk("defer_idle_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("defer_busy", 32'(load_busy), 32'd1);
      chk("defer_ready", 32'(in_ready), 32'd0);
      chk("defer_ce", 32'(ce), 32'd0);
    end
    chk("defer_sec_din", 32'(sec_din), 32'(hist[hist.size()-1]));
    tick();
    in_valid = 1'b0;
    #1;
    chk("defer_end_busy", 32'(load_busy), 32'd0);
    chk("defer_end_ready", 32'(in_ready), 32'd1);
    stream(5, 0);

    // load_start and in_valid together: load wins
    wait_ready();
    load_start = 1'b1;
    in_valid = 1'b1;
    din = 27'h1234567;
    #1;
    chk("tie_ready", 32'(in_ready), 32'd0);
    tick();
    load_start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("tie_busy", 32'(load_busy), 32'd1);
    cnt = 1;
    for (int i = 0; i < 40 && load_busy; i++) begin
      tick();
      if (load_busy) cnt++;
    end
    chk("tie_busy_len", 32'(cnt), 32'd17);
    chk("tie_sec_din", 32'(sec_din), 32'(hist[hist.size()-1]));

    // Reset pulse during F3
    wait_ready();
    in_valid = 1'b1;
    din = 27'h0ABCDEF;
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("midrst_f3_ce", 32'(ce), 32'd1);
    nrst = 1'b0;
    #1;
    chk("midrst_ce", 32'(ce), 32'd0);
    chk("midrst_msel", 32'(mult_sel), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_sec_din", 32'(sec_din), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(load_busy), 32'd0);
    tick();
    nrst = 1'b1;
    #1;
    chk("postrst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    din = 27'h0000123;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("postrst_sec_din", 32'(sec_din), 32'h0000123);
    tick();
    chk("postrst_ce", 32'(ce), 32'd1);
    chk("postrst_msel", 32'(mult_sel), 32'd1);
    tick(); tick(); tick(); tick();
    chk("postrst_idle_ready", 32'(in_ready), 32'd1);
    chk("postrst_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iir_cascade_ctrl.md
Name: iir_cascade_ctrl

Overview:
Sequencer and coefficient loader for a cascade of N_SEC second-order IIR sections sharing one control bus. It accepts input samples on a valid/ready handshake and latches each one for section 0. It generates the per-sample ce window and mult_sel pattern the sections require, and captures the last section's output with a valid strobe. It also loads all section coefficients from an external synchronous coefficient ROM after a load request.

Parameters:
N_SEC, 4, number of cascaded sections; 1..8
SAMP_WH, 4, sample integer bits, sign included
SAMP_FR, 23, sample fraction bits
COEFF_WH, 2, coefficient integer bits, sign included
COEFF_FR, 14, coefficient fraction bits

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  asynchronous active-low reset
load_start  in  1  request coefficient reload; 1-cycle pulse
load_busy  out  1  high while the coefficient load runs
rom_addr  out  $clog2(4*N_SEC)  coefficient ROM address
rom_data  in  COEFF_WH+COEFF_FR  ROM data, valid 1 cycle after rom_addr
c_we  out  N_SEC  per-section coefficient write enable, one-hot or zero
c_addr  out  2  coefficient slot: 0=a0, 1=a1, 2=b, 3=K
c_in  out  COEFF_WH+COEFF_FR  coefficient value broadcast to all sections
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
din  in  SAMP_WH+SAMP_FR  input sample, signed
sec_din  out  SAMP_WH+SAMP_FR  latched sample driven to section 0
ce  out  1  section accumulate enable, shared by all sections
mult_sel  out  1  section a-coefficient select, shared
last_dout  in  SAMP_WH+SAMP_FR  output of section N_SEC-1
dout  out  SAMP_WH+SAMP_FR  filtered sample, registered
out_valid  out  1  1-cycle strobe, dout is new

Behaviour:
- Reset values: load_busy=0, rom_addr=0, c_we=0, c_addr=0, c_in=0, in_ready=0, sec_din=0, ce=0, mult_sel=0, dout=0, out_valid=0, warm-up count=0, both FSMs in IDLE.
- First cycle after reset release: in_ready=1 only if no load is active.
- Frame FSM states: IDLE, F1, F2, F3, F4, CAP.
  - IDLE: in_ready=1. On in_valid&&in_ready: sec_din<=din, go to F1.
  - F1: ce=0, mult_sel=0.
  - F2: ce=1, mult_sel=1.
  - F3: ce=1, mult_sel=1.
  - F4: ce=0, mult_sel=0. The sections detect the ce falling edge and update their outputs at the end of F4.
  - CAP: dout<=last_dout. If warm-up count >= N_SEC-1, out_valid=1 in the following cycle. Warm-up count increments, saturating at N_SEC. Return to IDLE.
- in_ready=0 in every state except IDLE. Maximum throughput is one sample per 6 cycles.
- sec_din is held constant from the accept edge until the next accept.
- Cascade behaviour: sections run in lock-step, so section k+1 consumes section k's previous-frame output. Pipeline latency is N_SEC frames. The first N_SEC-1 captures after reset or after a load are suppressed: dout still updates, but out_valid stays 0.
- Load FSM states: LD_IDLE, LD_RUN, LD_LAST.
  - load_start is honoured only when both FSMs are idle. It wins over in_valid in the same cycle, so in_ready drops that cycle.
  - load_start arriving mid-frame is latched as pending and starts the load on the cycle the frame FSM returns to IDLE.
  - load_start while load_busy=1 is ignored.
  - LD_RUN: rom_addr steps 0..4*N_SEC-1, one per cycle. The write for address i happens one cycle later: c_we[i>>2]=1, c_addr=i[1:0], c_in=rom_data.
  - LD_LAST: performs the final write, then returns to LD_IDLE.
  - load_busy=1 from the cycle after load_start through the final write cycle. Total busy time is 4*N_SEC+1 cycles.
  - Load completion clears the warm-up count to 0.
- While load_busy=1: in_ready=0, ce=0. Section recursion state is not cleared by a load.
- Reset asserted mid-frame or mid-load aborts immediately to reset values. A partially written coefficient set is left as-is in the sections.
- No arithmetic is performed in this block; it only routes and registers data.

Decomposition:
- Shared package iir_pkg: slot encoding constants C_A0=0, C_A1=1, C_B=2, C_K=3; frame FSM and load FSM state enums; sample and coefficient width constants.
- One sub-module is natural: iir_coef_loader, containing the load FSM, ROM address counter and c_we decode. The frame FSM stays in the top.

Test Plan:
- Reset then load_start with N_SEC=4 -> load_busy high 17 cycles; 16 writes with c_we one-hot 0001,0001,0001,0001,0010,...,1000; c_addr cycles 0,1,2,3; c_in equals ROM[i].
- Single sample din=0x0400000 after load -> sec_din=0x0400000; ce high exactly 2 cycles; mult_sel high exactly during those 2 cycles; 6 cycles from accept to IDLE; no out_valid.
- Continuous in_valid=1 with N_SEC=4 and a unity-passthrough section model -> first out_valid on the 4th capture; then one out_valid every 6 cycles; dout equals the sample accepted 3 frames earlier.
- load_start asserted during F2 -> load deferred until IDLE, then runs 17 cycles; in_ready=0 throughout; warm-up restarts, so the next 3 captures have no out_valid.
- load_start and in_valid asserted in the same IDLE cycle -> load starts; sample not accepted; sec_din unchanged.
- nrst pulsed low during F3 -> ce=0 and out_valid=0 at once; all outputs at reset values; after release a new sample is accepted normally.
